vga_timing_gen: RTL and testbench

//  Source end of the pixel-timing bus consumed by draw_background and later draw stages.

---
 rtl/vga_timing_gen_pkg.sv | 30 +++
 rtl/vga_timing_gen_mod_counter.sv | 24 ++
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// XGA pixel-timing constants and game mode encodings
// shared by the timing generator and the draw stages.
package vga_timing_gen_pkg;

  localparam int H_ACTIVE     = 1024;
  localparam int H_SYNC_START = 1048;
  localparam int H_SYNC_W     = 136;
  localparam int H_TOTAL      = 1344;
  localparam int V_ACTIVE     = 768;
  localparam int V_SYNC_START = 771;
  localparam int V_SYNC_W     = 6;
  localparam int V_TOTAL      = 806;

  typedef enum logic [2:0] {
    MENU_MODE    = 3'b000,
    GAME_MODE    = 3'b001,
    VICTORY_MODE = 3'b010,
    GAME_OVER    = 3'b011,
    MULTI_WAIT   = 3'b100
  } mode_e;

  function automatic logic in_range(
    input logic [11:0] x,
    input logic [11:0] lo,
    input logic [11:0] w
  );
    return (x >= lo) && (x < lo + w);
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MOD up counter; wrap flags the last count
// so a following counter can be chained on it.
module mod_counter #(
  parameter int MOD   = 1344,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = (count == WIDTH'(MOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing source: position, syncs, blanks, start of frame,
// frame count and a game-mode latch that only moves at frame start.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACT  = H_ACTIVE,
  parameter int H_SS   = H_SYNC_START,
  parameter int H_SW   = H_SYNC_W,
  parameter int H_TOT  = H_TOTAL,
  parameter int V_ACT  = V_ACTIVE,
  parameter int V_SS   = V_SYNC_START,
  parameter int V_SW   = V_SYNC_W,
  parameter int V_TOT  = V_TOTAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  control_state_in,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        sof_out,
  output logic [15:0] frame_cnt_out,
  output logic [2:0]  control_state_out
);

  localparam logic [11:0] HA  = 12'(H_ACT);
  localparam logic [11:0] HSS = 12'(H_SS);
  localparam logic [11:0] HSW = 12'(H_SW);
  localparam logic [11:0] VA  = 12'(V_ACT);
  localparam logic [11:0] VSS = 12'(V_SS);
  localparam logic [11:0] VSW = 12'(V_SW);

  logic        h_wrap;
  logic        v_wrap;
  logic        f_wrap;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;

  mod_counter #(.MOD(H_TOT), .WIDTH(12)) u_h (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (hcount_out),
    .wrap  (h_wrap)
  );

  mod_counter #(.MOD(V_TOT), .WIDTH(12)) u_v (
    .clk   (clk),
    .rst   (rst),
    .en    (en && h_wrap),
    .count (vcount_out),
    .wrap  (v_wrap)
  );

  assign f_wrap = h_wrap && v_wrap;

  // Flags decode the position the counters move to on this edge
  always_comb begin
    h_nxt = hcount_out + 1'b1;
    v_nxt = vcount_out;
    if (h_wrap) begin
      h_nxt = '0;
      v_nxt = v_wrap ? '0 : vcount_out + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_out         <= 1'b0;
      vsync_out         <= 1'b0;
      hblnk_out         <= 1'b0;
      vblnk_out         <= 1'b0;
      sof_out           <= 1'b0;
      frame_cnt_out     <= '0;
      control_state_out <= MENU_MODE;
    end else if (en) begin
      hsync_out <= in_range(h_nxt, HSS, HSW);
      vsync_out <= in_range(v_nxt, VSS, VSW);
      hblnk_out <= (h_nxt >= HA);
      vblnk_out <= (v_nxt >= VA);
      sof_out   <= f_wrap;
      if (f_wrap) begin
        frame_cnt_out     <= frame_cnt_out + 1'b1;
        control_state_out <= control_state_in;
      end
    end else begin
      sof_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster,
// checked cycle by cycle against a queued reference model.
module tb_vga_timing_gen;

  localparam int HA  = 16;
  localparam int HSS = 18;
  localparam int HSW = 4;
  localparam int HT  = 24;
  localparam int VA  = 10;
  localparam int VSS = 11;
  localparam int VSW = 2;
  localparam int VT  = 14;
  localparam int FR  = HT * VT;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        sof;
    logic [15:0] fc;
    logic [2:0]  cs;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en;
  logic [2:0]  cs_in;
  logic [11:0] hcount_out;
  logic [11:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic        sof_out;
  logic [15:0] frame_cnt_out;
  logic [2:0]  control_state_out;

  vga_timing_gen #(
    .H_ACT(HA), .H_SS(HSS), .H_SW(HSW), .H_TOT(HT),
    .V_ACT(VA), .V_SS(VSS), .V_SW(VSW), .V_TOT(VT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .control_state_in  (cs_in),
    .hcount_out        (hcount_out),
    .vcount_out        (vcount_out),
    .hsync_out         (hsync_out),
    .vsync_out         (vsync_out),
    .hblnk_out         (hblnk_out),
    .vblnk_out         (vblnk_out),
    .sof_out           (sof_out),
    .frame_cnt_out     (frame_cnt_out),
    .control_state_out (control_state_out)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  obs_t        q[$];
  int          mh;
  int          mv;
  logic [15:0] mf;
  logic [2:0]  ms;
  logic        msof;

  function automatic obs_t expect_now();
    obs_t e;
    e.h   = 12'(mh);
    e.v   = 12'(mv);
    e.hs  = (mh >= HSS) && (mh < HSS + HSW);
    e.vs  = (mv >= VSS) && (mv < VSS + VSW);
    e.hb  = (mh >= HA);
    e.vb  = (mv >= VA);
    e.sof = msof;
    e.fc  = mf;
    e.cs  = ms;
    return e;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
         vblnk_out, sof_out, frame_cnt_out, control_state_out};
    return o;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mf = '0; ms = 3'b000; msof = 1'b0;
  endtask

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    logic fw;
    if (!en) begin
      msof = 1'b0;
    end else begin
      fw = (mh == HT - 1) && (mv == VT - 1);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      msof = fw;
      if (fw) begin
        mf = mf + 16'd1;
        ms = cs_in;
      end
    end
    q.push_back(expect_now());
    @(posedge clk);
    #1;
    check(tag, observed(), q.pop_front());
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int cnt_c;
    int guard;
    en = 1'b1;
    cs_in = 3'b000;
    model_reset();

    #1 rst = 1'b0;
    #1 check("reset_async", observed(), expect_now());
    @(posedge clk); #1;
    check("reset_hold", observed(), expect_now());
    @(negedge clk);
    rst = 1'b1;
    #1 check("release_pre_edge", observed(), expect_now());
    @(posedge clk); #1;
    mh = 1;
    check("first_edge", observed(), expect_now());

    for (int i = 0; i < 29; i++) step("count");
    check_int("hcount_30", int'(hcount_out), 30 % HT);
    check_int("vcount_30", int'(vcount_out), 1);

    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < HT; i++) begin
      step("line");
      if (hsync_out) cnt_a++;
      if (hblnk_out) cnt_b++;
    end
    check_int("hsync_width", cnt_a, HSW);
    check_int("hblnk_width", cnt_b, HT - HA);

    guard = 0;
    while (!(mh == 0 && mv == 3) && guard < FR) begin
      step("seek_v3"); guard++;
    end
    check_int("seek_v3_bound", guard < FR ? 1 : 0, 1);
    cs_in = 3'b011;
    guard = 0;
    while (!sof_out && guard < FR) begin
      step("latch_wait");
      if (!sof_out) check_int("cs_before_sof", int'(control_state_out), 0);
      guard++;
    end
    check_int("sof_seen", int'(sof_out), 1);
    check_int("cs_game_over", int'(control_state_out), 3);
    check_int("frame_cnt_1", int'(frame_cnt_out), 1);
    check_int("wrap_pos", int'({hcount_out, vcount_out}), 0);

    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < FR; i++) begin
      if (i == 100) cs_in = 3'b010;
      if (i == 110) cs_in = 3'b011;
      step("frame");
      if (vsync_out) cnt_a++;
      if (vblnk_out) cnt_b++;
      if (sof_out) cnt_c++;
    end
    check_int("vsync_cycles", cnt_a, VSW * HT);
    check_int("vblnk_cycles", cnt_b, (VT - VA) * HT);
    check_int("sof_per_frame", cnt_c, 1);
    check_int("cs_pulse_ignored", int'(control_state_out), 3);
    check_int("frame_cnt_2", int'(frame_cnt_out), 2);

    while (mh != 5) step("seek_h5");
    cnt_a = int'(vcount_out);
    en = 1'b0;
    for (int i = 0; i < 50; i++) step("frozen");
    check_int("frozen_h", int'(hcount_out), 5);
    en = 1'b1;
    cnt_b = 0;
    do begin
      step("resume"); cnt_b++;
    end while (hcount_out != 12'd5 && cnt_b < 2 * HT);
    check_int("line_len_en", cnt_b, HT);
    check_int("line_len_v", int'(vcount_out), (cnt_a + 1) % VT);

    guard = 0;
    while (!sof_out && guard < 2 * FR) begin
      step("seek_sof"); guard++;
    end
    check_int("sof_seen2", int'(sof_out), 1);
    en = 1'b0;
    step("sof_drop");
    check_int("sof_not_stretched", int'(sof_out), 0);
    for (int i = 0; i < 3; i++) step("sof_hold");
    en = 1'b1;

    while (!(mh == 12 && mv == 7)) step("seek_mid");
    #2 rst = 1'b0;
    model_reset();
    #1 check("mid_reset_async", observed(), expect_now());
    check_int("mid_reset_fc", int'(frame_cnt_out), 0);
    @(posedge clk); #1;
    check("mid_reset_hold", observed(), expect_now());
    @(negedge clk);
    rst = 1'b1;
    cs_in = 3'b001;
    cnt_c = 0;
    for (int i = 0; i < FR - 1; i++) begin
      step("restart");
      if (sof_out) cnt_c++;
    end
    check_int("no_sof_after_reset", cnt_c, 0);
    step("restart_wrap");
    check_int("sof_after_frame", int'(sof_out), 1);
    check_int("cs_game", int'(control_state_out), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
